// File: rtl/score_counter.sv
// score_counter: 4-digit BCD run score with milestone pulse and registered digit tap for the HUD.
// Define SCORE_HISCORE_EN to build the session high-score capture; otherwise o_hiscore is tied to zero.
module score_counter #(
    parameter int FRAMES_PER_POINT = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_frame_tick,
    input  logic        i_running,
    input  logic        i_game_over,
    input  logic        i_restart,
    input  logic [1:0]  i_digit_sel,
    output logic [15:0] o_score,
    output logic [15:0] o_hiscore,
    output logic [3:0]  o_num,
    output logic        o_milestone
);
    logic [5:0]  pre;
    logic [15:0] score, score_inc;
    logic        cnt, inc, sat, carry;
    assign cnt = i_frame_tick && i_running && !i_game_over;
    assign inc = cnt && pre == 6'(FRAMES_PER_POINT - 1);
    assign sat = score == 16'h9999;
    always_comb begin
        score_inc = score;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            score_inc[4*i +: 4] = !carry ? score[4*i +: 4] :
                                  score[4*i +: 4] == 4'd9 ? 4'd0 : score[4*i +: 4] + 4'd1;
            carry = carry && score[4*i +: 4] == 4'd9;
        end
    end
    // ~i_digit_sel maps select 0 (thousands) onto the top nibble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre         <= '0;
            score       <= '0;
            o_num       <= '0;
            o_milestone <= 1'b0;
        end else begin
            o_milestone <= 1'b0;
            o_num       <= score[{~i_digit_sel, 2'b00} +: 4];
            if (i_restart) begin
                pre   <= '0;
                score <= '0;
            end else if (cnt) begin
                pre <= inc ? 6'd0 : pre + 6'd1;
                if (inc && !sat) begin
                    score       <= score_inc;
                    o_milestone <= score_inc[7:0] == 8'h00;
                end
            end
        end
    end
    assign o_score = score;
`ifdef SCORE_HISCORE_EN
    logic        go_q;
    logic [15:0] hiscore;
    // counting is blocked while game over is high, so the edge always sees a settled score
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            go_q    <= 1'b0;
            hiscore <= '0;
        end else begin
            go_q <= i_game_over;
            if (i_game_over && !go_q && score > hiscore) hiscore <= score;
        end
    end
    assign o_hiscore = hiscore;
`else
    assign o_hiscore = 16'h0000;
`endif
endmodule
